// File: rtl/db_bus_arbiter_pkg.sv
// Shared definitions for the data-bus arbiter: access codes, FSM encodings,
// request predicate and the forwarded bus payload.
package db_bus_arbiter_pkg;

    localparam int unsigned ACC_W  = 3;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef logic [ACC_W-1:0] mem_access_t;

    localparam mem_access_t MEM_ACCESS_NONE = 3'd0;
    localparam mem_access_t MEM_ACCESS_R    = 3'd1;
    localparam mem_access_t MEM_ACCESS_W    = 3'd2;
    localparam mem_access_t MEM_ACCESS_X    = 3'd3;

    localparam int unsigned ST_W = 2;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT0 = 2'd1;
    localparam logic [1:0] S_GRANT1 = 2'd2;

    // Address, write data and access type travel together through the mux.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        mem_access_t       acc;
    } db_req_t;

    // Only R/W/X count as a request; NONE and undefined encodings do not.
    function automatic logic req_valid(input mem_access_t t);
        return (t == MEM_ACCESS_R) || (t == MEM_ACCESS_W) || (t == MEM_ACCESS_X);
    endfunction

endpackage

// File: rtl/db_watchdog_counter.sv
// Counts granted cycles without slave completion; flags the terminal count.
module db_watchdog_counter #(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic res,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc_c
);

    logic [CNT_W-1:0] r_cnt;

    // Clear has priority over counting so a fresh grant always starts at zero.
    always_ff @(posedge clk) begin
        if (res || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A zero timeout disables the terminal count entirely.
    assign o_tc_c = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/db_bus_arbiter.sv
// Round-robin two-master arbiter for the shared data bus, with a watchdog
// that force-releases a grant the slave never completes.
module db_bus_arbiter
    import db_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_dataOut,
    input  mem_access_t       m0_accessType,
    output logic [31:0]       m0_dataIn,
    output logic              m0_ready,
    output logic              m0_err,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_dataOut,
    input  mem_access_t       m1_accessType,
    output logic [31:0]       m1_dataIn,
    output logic              m1_ready,
    output logic              m1_err,
    output logic [31:0]       db_addr,
    output logic [31:0]       db_dataOut,
    output mem_access_t       db_accessType,
    input  logic [31:0]       db_dataIn,
    input  logic              db_ready,
    output logic [1:0]        grant,
    output logic              busTimeout
);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_state_nxt;
    logic [1:0]      r_grant;
    logic            r_last;
    logic            w_last_nxt;
    logic            r_bus_timeout;
    logic            w_timeout;
    logic            w_tc;
    logic            w_req0;
    logic            w_req1;
    logic            w_m0_ready;
    logic            w_m1_ready;
    logic            w_m0_err;
    logic            w_m1_err;
    db_req_t         w_m0_req;
    db_req_t         w_m1_req;
    db_req_t         w_db_req;

    assign w_req0   = req_valid(m0_accessType);
    assign w_req1   = req_valid(m1_accessType);
    assign w_m0_req = '{addr: m0_addr, data: m0_dataOut, acc: m0_accessType};
    assign w_m1_req = '{addr: m1_addr, data: m1_dataOut, acc: m1_accessType};

    // Watchdog restarts on every state change and counts stalled granted cycles.
    db_watchdog_counter #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .res      (res),
        .i_clear  (w_state_nxt != r_state),
        .i_enable ((r_state != S_IDLE) && !db_ready),
        .o_tc_c   (w_tc)
    );

    // Next-state, pointer update and combinational bus forwarding.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_timeout   = 1'b0;
        w_m0_ready  = 1'b0;
        w_m1_ready  = 1'b0;
        w_m0_err    = 1'b0;
        w_m1_err    = 1'b0;
        w_db_req    = '{addr: '0, data: '0, acc: MEM_ACCESS_NONE};
        if (!res) begin
            case (r_state)
                S_IDLE: begin
                    if (w_req0 && w_req1) begin
                        w_state_nxt = r_last ? S_GRANT0 : S_GRANT1;
                    end else if (w_req0) begin
                        w_state_nxt = S_GRANT0;
                    end else if (w_req1) begin
                        w_state_nxt = S_GRANT1;
                    end
                end
                S_GRANT0: begin
                    w_db_req = w_m0_req;
                    if (!w_req0) begin
                        w_db_req.acc = MEM_ACCESS_NONE;
                    end
                    if (db_ready) begin
                        w_m0_ready  = 1'b1;
                        w_last_nxt  = 1'b0;
                        w_state_nxt = w_req1 ? S_GRANT1 : S_IDLE;
                    end else if (!w_req0) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_tc) begin
                        w_m0_err    = 1'b1;
                        w_timeout   = 1'b1;
                        w_last_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_GRANT1: begin
                    w_db_req = w_m1_req;
                    if (!w_req1) begin
                        w_db_req.acc = MEM_ACCESS_NONE;
                    end
                    if (db_ready) begin
                        w_m1_ready  = 1'b1;
                        w_last_nxt  = 1'b1;
                        w_state_nxt = w_req0 ? S_GRANT0 : S_IDLE;
                    end else if (!w_req1) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_tc) begin
                        w_m1_err    = 1'b1;
                        w_timeout   = 1'b1;
                        w_last_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, one-hot grant, last-owner pointer and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state       <= S_IDLE;
            r_grant       <= 2'b00;
            r_last        <= 1'b1;
            r_bus_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= {w_state_nxt == S_GRANT1, w_state_nxt == S_GRANT0};
            r_last        <= w_last_nxt;
            r_bus_timeout <= r_bus_timeout | w_timeout;
        end
    end

    assign db_addr       = w_db_req.addr;
    assign db_dataOut    = w_db_req.data;
    assign db_accessType = w_db_req.acc;
    assign m0_dataIn     = db_dataIn;
    assign m1_dataIn     = db_dataIn;
    assign m0_ready      = w_m0_ready;
    assign m1_ready      = w_m1_ready;
    assign m0_err        = w_m0_err;
    assign m1_err        = w_m1_err;
    assign grant         = r_grant;
    assign busTimeout    = r_bus_timeout;

endmodule
